// File: rtl/xbar_port_arbiter.sv
// Round-robin arbiter granting one of four input-port queues access to the crossbar,
// with a per-grant watchdog that forces release of a stalled transfer.
module xbar_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_WIDTH       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_adr,
  input  logic [31:0] req_tq,
  input  logic        xbar_done,
  output logic [3:0]  grant,
  output logic [15:0] gnt_adr,
  output logic [7:0]  gnt_tq,
  output logic [1:0]  xbar_sel,
  output logic        xfer_start,
  output logic [3:0]  done_ack,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  localparam logic [TO_WIDTH-1:0] WdLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          rr_q, rr_d;
  logic [3:0]          grant_q, grant_d;
  logic [15:0]         adr_q, adr_d;
  logic [7:0]          tq_q, tq_d;
  logic [1:0]          sel_q, sel_d;
  logic                xs_q, xs_d;
  logic [3:0]          ack_q, ack_d;
  logic                to_q, to_d;
  logic                busy_q, busy_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;

  logic [1:0] pick;
  logic [1:0] cand;

  // Walk from the lowest to the highest priority so the closest requester after rr_q wins.
  always_comb begin
    pick = rr_q + 2'd1;
    cand = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k + 1);
      if (req_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    adr_d   = adr_q;
    tq_d    = tq_q;
    sel_d   = sel_q;
    xs_d    = 1'b0;
    ack_d   = ack_q;
    to_d    = 1'b0;
    wd_d    = wd_q + TO_WIDTH'(1);

    unique case (state_q)
      StIdle: begin
        wd_d = '0;
        if (|req_valid) begin
          grant_d = 4'b0001 << pick;
          sel_d   = pick;
          adr_d   = req_adr[{pick, 4'b0000} +: 16];
          tq_d    = req_tq[{pick, 3'b000} +: 8];
          xs_d    = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (xbar_done) begin
          ack_d   = grant_q;
          state_d = StRelease;
        end else if (!req_valid[sel_q]) begin
          // Queue withdrew its request: abort silently, no transmit_done.
          grant_d = '0;
          adr_d   = '0;
          tq_d    = '0;
          sel_d   = '0;
          rr_d    = sel_q;
          state_d = StIdle;
        end else if (wd_q == WdLast) begin
          to_d    = 1'b1;
          ack_d   = grant_q;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!req_valid[sel_q]) begin
          grant_d = '0;
          adr_d   = '0;
          tq_d    = '0;
          sel_d   = '0;
          ack_d   = '0;
          rr_d    = sel_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= 2'd3;
      grant_q <= '0;
      adr_q   <= '0;
      tq_q    <= '0;
      sel_q   <= '0;
      xs_q    <= 1'b0;
      ack_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      adr_q   <= adr_d;
      tq_q    <= tq_d;
      sel_q   <= sel_d;
      xs_q    <= xs_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
    end
  end

  assign grant       = grant_q;
  assign gnt_adr     = adr_q;
  assign gnt_tq      = tq_q;
  assign xbar_sel    = sel_q;
  assign xfer_start  = xs_q;
  assign done_ack    = ack_q;
  assign timeout_err = to_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Bench for xbar_port_arbiter: fixed vector table, directed corner sequences and a
// randomized run compared cycle by cycle against a transaction-level reference model.
module tb_xbar_port_arbiter;

  localparam int TO  = 8;
  localparam int TOW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_adr;
  logic [31:0] req_tq;
  logic        xbar_done;
  logic [3:0]  grant;
  logic [15:0] gnt_adr;
  logic [7:0]  gnt_tq;
  logic [1:0]  xbar_sel;
  logic        xfer_start;
  logic [3:0]  done_ack;
  logic        timeout_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  xbar_port_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH      (TOW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_adr    (req_adr),
    .req_tq     (req_tq),
    .xbar_done  (xbar_done),
    .grant      (grant),
    .gnt_adr    (gnt_adr),
    .gnt_tq     (gnt_tq),
    .xbar_sel   (xbar_sel),
    .xfer_start (xfer_start),
    .done_ack   (done_ack),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 transferring, 2 waiting for the queue to drop.
  int         m_phase, m_win, m_last, m_cycles;
  logic [3:0] m_grant, m_ack;
  logic [15:0] m_adr;
  logic [7:0] m_tq;
  logic [1:0] m_sel;
  logic       m_xs, m_to;

  function automatic logic [36:0] pack(input logic [3:0] g, input logic [15:0] a,
                                       input logic [7:0] t, input logic [1:0] s, input logic x,
                                       input logic [3:0] k, input logic o, input logic b);
    return {g, a, t, s, x, k, o, b};
  endfunction

  function automatic logic [36:0] dut_vec();
    return pack(grant, gnt_adr, gnt_tq, xbar_sel, xfer_start, done_ack, timeout_err, busy);
  endfunction

  function automatic logic [36:0] model_vec();
    return pack(m_grant, m_adr, m_tq, m_sel, m_xs, m_ack, m_to, m_phase != 0);
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_idle();
    m_phase = 0; m_grant = '0; m_adr = '0; m_tq = '0; m_sel = '0; m_ack = '0;
  endtask

  task automatic model_reset();
    model_idle();
    m_last = 3; m_win = 0; m_cycles = 0; m_xs = 0; m_to = 0;
  endtask

  task automatic model_step();
    int w;
    m_xs = 0;
    m_to = 0;
    case (m_phase)
      0: if (req_valid != 4'b0000) begin
        w = (m_last + 1) % 4;
        while (!req_valid[w]) w = (w + 1) % 4;
        m_win = w; m_phase = 1; m_cycles = 0; m_xs = 1;
        m_grant = 4'(1 << w); m_sel = 2'(w);
        m_adr = req_adr[w*16 +: 16]; m_tq = req_tq[w*8 +: 8];
      end
      1: begin
        if (xbar_done) begin
          m_ack = m_grant; m_phase = 2;
        end else if (!req_valid[m_win]) begin
          m_last = m_win; model_idle();
        end else if (m_cycles == TO - 1) begin
          m_to = 1; m_ack = m_grant; m_phase = 2;
        end
        m_cycles++;
      end
      default: if (!req_valid[m_win]) begin
        m_last = m_win; model_idle();
      end
    endcase
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; xbar_done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_state", dut_vec(), '0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic        done;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [15:0] adr;
    logic [7:0]  tq;
    logic        xs;
    logic [3:0]  ack;
    logic        to;
    logic        busy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL tb_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g;

    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 16'h1234, 8'h05, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 16'h1234, 8'h05, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 16'h1234, 8'h05, 1'b0, 4'b0100, 1'b0, 1'b1};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 16'h1234, 8'h05, 1'b0, 4'b0100, 1'b0, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 16'h0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 16'h0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 16'hABCD, 8'h77, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{4'b0011, 1'b0, 4'b0010, 2'd1, 16'hABCD, 8'h77, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0000, 2'd0, 16'h0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 16'h0F0F, 8'h11, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 16'h0F0F, 8'h11, 1'b0, 4'b0001, 1'b0, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 16'h0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0};

    req_adr = 64'h4444_1234_ABCD_0F0F;
    req_tq  = 32'h99_05_77_11;
    do_reset();

    // Single request, non-winner noise, abort, and release via the vector table.
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].rv;
      xbar_done = tbl[i].done;
      tick($sformatf("model_tbl%0d", i));
      check($sformatf("tbl%0d", i), dut_vec(),
            pack(tbl[i].grant, tbl[i].adr, tbl[i].tq, tbl[i].sel, tbl[i].xs, tbl[i].ack,
                 tbl[i].to, tbl[i].busy));
    end

    // Round robin with all four requesting; one idle cycle between grants.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      exp_g = 4'(1 << (f % 4));
      req_valid = 4'b1111; xbar_done = 1'b0;
      tick("rr_grant_model");
      check($sformatf("rr_grant%0d", f), {33'd0, grant}, {33'd0, exp_g});
      xbar_done = 1'b1;
      tick("rr_done_model");
      check($sformatf("rr_ack%0d", f), {33'd0, done_ack}, {33'd0, exp_g});
      xbar_done = 1'b0; req_valid = 4'b1111 & ~exp_g;
      tick("rr_idle_model");
      check($sformatf("rr_idle%0d", f), {35'd0, busy, xfer_start}, '0);
    end

    // Timeout 8 cycles after xfer_start, then ack held across a watchdog wrap.
    do_reset();
    req_valid = 4'b0100;
    tick("to_grant");
    for (int k = 1; k <= 8; k++) begin
      tick("to_model");
      check($sformatf("to_pulse%0d", k), {32'd0, timeout_err, done_ack},
            {32'd0, (k == 8), (k == 8) ? 4'b0100 : 4'b0000});
    end
    for (int k = 0; k < 12; k++) begin
      tick("to_hold_model");
      check("to_hold", {32'd0, timeout_err, done_ack}, {32'd0, 1'b0, 4'b0100});
    end
    req_valid = 4'b0000;
    tick("to_release");

    // Collision: done in the expiry cycle wins over the timeout.
    req_valid = 4'b0100;
    tick("col_grant");
    for (int k = 1; k < 8; k++) tick("col_wait");
    xbar_done = 1'b1;
    tick("col_model");
    check("collision", {32'd0, timeout_err, done_ack}, {32'd0, 1'b0, 4'b0100});
    xbar_done = 1'b0; req_valid = 4'b0000;
    tick("col_release");

    // Abort in the expiry cycle beats the timeout; no ack ever.
    req_valid = 4'b1000;
    tick("ab_grant");
    for (int k = 1; k < 8; k++) tick("ab_wait");
    req_valid = 4'b0000;
    tick("ab_model");
    check("abort_vs_timeout", {28'd0, grant, timeout_err, done_ack}, '0);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    req_valid = 4'b0010;
    tick("rst_grant_model");
    check("rst_pre_grant", {33'd0, grant}, {33'd0, 4'b0010});
    #3;
    reset = 1'b1;
    #1;
    check("rst_async", dut_vec(), '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 4'b1111;
    tick("rst_after_model");
    check("rst_first_grant", {33'd0, grant}, {33'd0, 4'b0001});

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_adr   = {$urandom, $urandom};
      req_tq    = $urandom;
      req_valid = 4'($urandom);
      if (m_phase == 1) req_valid[m_win] = ($urandom_range(0, 7) != 0);
      if (m_phase == 2) req_valid[m_win] = ($urandom_range(0, 2) != 0);
      xbar_done = ($urandom_range(0, 9) == 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
